// File: rtl/input_event_capture_pkg.sv
// input_event_capture_pkg: edge_mode encodings, pulse-width FSM states and edge qualification helper.
package input_event_capture_pkg;
    localparam logic [1:0] EDGE_NONE = 2'b00;
    localparam logic [1:0] EDGE_RISE = 2'b01;
    localparam logic [1:0] EDGE_FALL = 2'b10;
    localparam logic [1:0] EDGE_BOTH = 2'b11;

    typedef enum logic {PW_IDLE, PW_MEASURE} pw_state_e;

    function automatic logic edge_selected(input logic [1:0] mode, input logic rise, input logic fall);
        return (mode != EDGE_NONE) && ((rise && mode != EDGE_FALL) || (fall && mode inside {EDGE_FALL, EDGE_BOTH}));
    endfunction
endpackage

// File: rtl/input_event_capture_edge_detect.sv
// edge_detect: registers the synchronised input and flags rise/fall once primed after reset.
module edge_detect
    import input_event_capture_pkg::*;
(
    input  logic clk,
    input  logic resn,
    input  logic sync_in,
    output logic rise,
    output logic fall
);
    logic prev_q, prev_d, primed_q, primed_d;

    always_comb begin
        prev_d   = sync_in;
        primed_d = 1'b1;
    end

    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            prev_q   <= 1'b0;
            primed_q <= 1'b0;
        end else begin
            prev_q   <= prev_d;
            primed_q <= primed_d;
        end
    end

    assign rise = primed_q & sync_in & ~prev_q;
    assign fall = primed_q & ~sync_in & prev_q;
endmodule

// File: rtl/input_event_capture.sv
// input_event_capture: qualified edge counter with sticky irq/overflow; optional high-pulse
// width measurement compiled in when PULSE_WIDTH_EN is defined.
module input_event_capture
    import input_event_capture_pkg::*;
#(
    parameter int CNT_WIDTH = 16,
    parameter int PW_WIDTH  = 24
) (
    input  logic                 clk,
    input  logic                 resn,
    input  logic                 sync_in,
    input  logic                 enable,
    input  logic [1:0]           edge_mode,
    input  logic                 clear,
    output logic                 event_pulse,
    output logic [CNT_WIDTH-1:0] event_count,
    output logic                 irq_pending,
    output logic                 overflow,
    output logic [PW_WIDTH-1:0]  pulse_width,
    output logic                 pulse_width_valid
);
    logic rise, fall, qual;
    logic event_pulse_q, event_pulse_d, irq_q, irq_d, ovf_q, ovf_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;

    edge_detect u_edge (
        .clk     (clk),
        .resn    (resn),
        .sync_in (sync_in),
        .rise    (rise),
        .fall    (fall)
    );

    // Clear wins over history but a coincident edge still lands in the fresh state.
    always_comb begin
        qual          = enable && edge_selected(edge_mode, rise, fall);
        event_pulse_d = qual;
        irq_d         = (irq_q && !clear) || qual;
        ovf_d         = !clear && (ovf_q || (qual && &count_q));
        count_d       = clear ? CNT_WIDTH'(qual) : (qual && !(&count_q)) ? count_q + 1'b1 : count_q;
    end

    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            event_pulse_q <= 1'b0;
            irq_q         <= 1'b0;
            ovf_q         <= 1'b0;
            count_q       <= '0;
        end else begin
            event_pulse_q <= event_pulse_d;
            irq_q         <= irq_d;
            ovf_q         <= ovf_d;
            count_q       <= count_d;
        end
    end

    assign event_pulse = event_pulse_q;
    assign event_count = count_q;
    assign irq_pending = irq_q;
    assign overflow    = ovf_q;

`ifdef PULSE_WIDTH_EN
    pw_state_e state_q, state_d;
    logic [PW_WIDTH-1:0] pw_cnt_q, pw_cnt_d, pw_q, pw_d;
    logic pw_valid_q, pw_valid_d;

    always_comb begin
        state_d    = state_q;
        pw_cnt_d   = pw_cnt_q;
        pw_d       = pw_q;
        pw_valid_d = 1'b0;
        if (state_q == PW_IDLE) begin
            if (rise && enable) begin
                state_d  = PW_MEASURE;
                pw_cnt_d = PW_WIDTH'(1);
            end
        end else if (!enable || clear) begin
            state_d = PW_IDLE;
        end else if (fall) begin
            state_d    = PW_IDLE;
            pw_d       = pw_cnt_q;
            pw_valid_d = 1'b1;
        end else if (sync_in && !(&pw_cnt_q)) begin
            pw_cnt_d = pw_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            state_q    <= PW_IDLE;
            pw_cnt_q   <= '0;
            pw_q       <= '0;
            pw_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pw_cnt_q   <= pw_cnt_d;
            pw_q       <= pw_d;
            pw_valid_q <= pw_valid_d;
        end
    end

    assign pulse_width       = pw_q;
    assign pulse_width_valid = pw_valid_q;
`else
    assign pulse_width       = '0;
    assign pulse_width_valid = 1'b0;
`endif
endmodule

// File: tb/tb_input_event_capture.sv
// tb_input_event_capture: directed stimulus on a 16-bit and a 2-bit-counter instance, checked
// every cycle against a timestamp-based reference model plus literal expectations.
module tb_input_event_capture;
    logic clk = 1'b0, resn = 1'b1, sync_in = 1'b0, enable = 1'b0, clear = 1'b0;
    logic [1:0] edge_mode = 2'b00;
    logic ev0, irq0, ovf0, pwv0, ev1, irq1, ovf1, pwv1;
    logic [15:0] cnt0;
    logic [1:0]  cnt1;
    logic [23:0] pw0;
    logic [2:0]  pw1;
    int checks = 0, errors = 0;
    bit chk_en = 0;

`ifdef PULSE_WIDTH_EN
    localparam bit PW_EN = 1'b1;
`else
    localparam bit PW_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    input_event_capture u_dut16 (
        .clk(clk), .resn(resn), .sync_in(sync_in), .enable(enable), .edge_mode(edge_mode), .clear(clear),
        .event_pulse(ev0), .event_count(cnt0), .irq_pending(irq0), .overflow(ovf0),
        .pulse_width(pw0), .pulse_width_valid(pwv0)
    );

    input_event_capture #(.CNT_WIDTH(2), .PW_WIDTH(3)) u_dut2 (
        .clk(clk), .resn(resn), .sync_in(sync_in), .enable(enable), .edge_mode(edge_mode), .clear(clear),
        .event_pulse(ev1), .event_count(cnt1), .irq_pending(irq1), .overflow(ovf1),
        .pulse_width(pw1), .pulse_width_valid(pwv1)
    );

    // Reference model: edges from the last sampled level, pulse widths from cycle timestamps.
    int  cmax[2] = '{65535, 3};
    int  pmax[2] = '{16777215, 7};
    int  m_cnt[2], m_pw[2];
    bit  m_ovf[2];
    bit  m_pulse, m_irq, m_pwv, primed, last, measuring, r, f, q;
    int  cyc, start;

    always @(posedge clk or negedge resn) begin
        if (!resn) begin
            primed = 0; last = 0; measuring = 0; m_pulse = 0; m_irq = 0; m_pwv = 0;
            for (int i = 0; i < 2; i++) begin m_cnt[i] = 0; m_ovf[i] = 0; m_pw[i] = 0; end
        end else begin
            r = primed && sync_in && !last;
            f = primed && !sync_in && last;
            q = enable && ((r && edge_mode[0]) || (f && edge_mode[1]));
            for (int i = 0; i < 2; i++) begin
                if (clear) begin
                    m_cnt[i] = q ? 1 : 0;
                    m_ovf[i] = 0;
                end else if (q) begin
                    if (m_cnt[i] == cmax[i]) m_ovf[i] = 1;
                    else m_cnt[i] = m_cnt[i] + 1;
                end
            end
            m_pulse = q;
            m_irq = (m_irq && !clear) || q;
            m_pwv = 0;
            if (measuring) begin
                if (!enable || clear) measuring = 0;
                else if (f) begin
                    for (int i = 0; i < 2; i++) m_pw[i] = (cyc - start > pmax[i]) ? pmax[i] : cyc - start;
                    m_pwv = 1;
                    measuring = 0;
                end
            end else if (r && enable) begin
                measuring = 1;
                start = cyc;
            end
            cyc++;
            last = sync_in;
            primed = 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            check("pulse16", 32'(ev0), 32'(m_pulse));
            check("count16", 32'(cnt0), m_cnt[0]);
            check("irq16", 32'(irq0), 32'(m_irq));
            check("ovf16", 32'(ovf0), 32'(m_ovf[0]));
            check("pw16", 32'(pw0), PW_EN ? m_pw[0] : 0);
            check("pwv16", 32'(pwv0), 32'(PW_EN && m_pwv));
            check("pulse2", 32'(ev1), 32'(m_pulse));
            check("count2", 32'(cnt1), m_cnt[1]);
            check("irq2", 32'(irq1), 32'(m_irq));
            check("ovf2", 32'(ovf1), 32'(m_ovf[1]));
            check("pw2", 32'(pw1), PW_EN ? m_pw[1] : 0);
            check("pwv2", 32'(pwv1), 32'(PW_EN && m_pwv));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #1;
        resn = 0; sync_in = 1; enable = 1; edge_mode = 2'b01; chk_en = 1;
        step(3);
        resn = 1;
        step(1);
        check("lit_reset_pulse", 32'(ev0), 0);
        step(2);
        check("lit_reset_count", 32'(cnt0), 0);

        for (int i = 0; i < 3; i++) begin
            sync_in = 0; step(2);
            sync_in = 1; step(1);
            check("lit_rise_pulse", 32'(ev0), 1);
            step(1);
            check("lit_rise_pulse_end", 32'(ev0), 0);
        end
        check("lit_three_count", 32'(cnt0), 3);
        check("lit_three_irq", 32'(irq0), 1);

        clear = 1; step(1); clear = 0;
        check("lit_clear_count", 32'(cnt0), 0);
        step(1);

        edge_mode = 2'b11;
        for (int i = 1; i <= 5; i++) begin
            sync_in = ~sync_in; step(1);
            check("lit_sat_ovf2", 32'(ovf1), (i >= 4) ? 1 : 0);
            check("lit_sat_count2", 32'(cnt1), (i > 3) ? 3 : i);
            step(1);
        end
        check("lit_five_count16", 32'(cnt0), 5);

        sync_in = 1; clear = 1; step(1); clear = 0;
        check("lit_clr_edge_count", 32'(cnt1), 1);
        check("lit_clr_edge_irq", 32'(irq1), 1);
        check("lit_clr_edge_ovf", 32'(ovf1), 0);

        edge_mode = 2'b01;
        sync_in = 0; step(2);
        sync_in = 1; step(7);
        sync_in = 0; step(1);
`ifdef PULSE_WIDTH_EN
        check("lit_pw7", 32'(pw0), 7);
        check("lit_pw7_valid", 32'(pwv0), 1);
`endif
        step(1);
        check("lit_pw7_valid_end", 32'(pwv0), 0);
        step(1);
        sync_in = 1; step(10);
        sync_in = 0; step(1);
`ifdef PULSE_WIDTH_EN
        check("lit_pw10", 32'(pw0), 10);
        check("lit_pw_sat", 32'(pw1), 7);
`endif
        step(2);
        sync_in = 1; step(3);
        enable = 0; step(1);
        enable = 1; step(2);
        sync_in = 0; step(1);
        check("lit_abort_valid", 32'(pwv0), 0);
        step(2);

        enable = 0; sync_in = 1; step(1);
        check("lit_dis_pulse", 32'(ev0), 0);
        enable = 1; step(1);
        check("lit_reen_pulse", 32'(ev0), 0);
        step(2);
        sync_in = 0; step(2);
        check("lit_end_count16", 32'(cnt0), 4);
        check("lit_end_count2", 32'(cnt1), 3);
        check("lit_end_ovf2", 32'(ovf1), 1);

        sync_in = 1; step(3);
        resn = 0; step(1);
        check("lit_rst_count", 32'(cnt0), 0);
        sync_in = 0; resn = 1; step(4);
        check("lit_rst_valid", 32'(pwv0), 0);
        check("lit_rst_count_after", 32'(cnt0), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
